// File: rtl/alu_seq_driver.sv
// BIST stimulus driver for the registered ALU: issues LFSR operand pairs and
// checks each alu_out result against a prediction delayed by the ALU latency.
module alu_seq_driver #(
    parameter int          W       = 4,
    parameter int          OUT_W   = 8,
    parameter int          LATENCY = 1,
    parameter int          CNT_W   = 8,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic [2:0]       op_mode,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [OUT_W-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err
);

    // Handshake: start is a level sampled only in IDLE; done is high for exactly
    // the one DONE cycle; pass/err_count/first_err are stable from done until the
    // next accepted start.
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam int         DW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t           state;
    logic [7:0]       lfsr;
    logic [CNT_W-1:0] num_q;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] op_idx;
    logic [CNT_W-1:0] idx_inc;
    logic [DW-1:0]    drain_cnt;
    logic [CNT_W-1:0] err_nxt;
    logic             cmp_hit;

    logic [OUT_W-1:0] exp_pipe [LATENCY];
    logic [CNT_W-1:0] idx_pipe [LATENCY];
    logic [LATENCY-1:0] vld_pipe;

    // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [OUT_W-1:0] predict(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input logic [1:0]   op);
        logic [OUT_W-1:0] ax;
        logic [OUT_W-1:0] bx;
        ax = OUT_W'(a);
        bx = OUT_W'(b);
        case (op)
            2'd0:    return ax + bx;
            2'd1:    return ax | bx;
            2'd2:    return ax - bx;
            default: return ax ^ bx;
        endcase
    endfunction

    assign busy    = (state == ISSUE) || (state == DRAIN);
    assign done    = (state == DONE);
    assign idx_inc = op_idx + 1'b1;
    assign cmp_hit = vld_pipe[LATENCY-1] && (alu_out != exp_pipe[LATENCY-1]);

    always_comb begin
        err_nxt = err_count;
        if (cmp_hit && (err_count != '1))
            err_nxt = err_count + 1'b1;
    end

    // Prediction pipeline: the operands on the ALU port this cycle produce the
    // alu_out seen LATENCY cycles later, so the expectation travels alongside.
    always_ff @(posedge clk) begin
        exp_pipe[0] <= predict(alu_a, alu_b, alu_opcode);
        idx_pipe[0] <= op_idx;
        for (int i = 1; i < LATENCY; i++) begin
            exp_pipe[i] <= exp_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
        end
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= (state == ISSUE);
            for (int i = 1; i < LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            num_q      <= '0;
            mode_q     <= '0;
            op_idx     <= '0;
            drain_cnt  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_err  <= '0;
        end else begin
            err_count <= err_nxt;
            if (cmp_hit && (err_count == '0))
                first_err <= idx_pipe[LATENCY-1];
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q     <= num_ops;
                        mode_q    <= op_mode;
                        op_idx    <= '0;
                        err_count <= '0;
                        first_err <= '0;
                        if (num_ops == '0) begin
                            state <= DONE;
                            lfsr  <= SEED_EFF;
                            pass  <= 1'b1;
                        end else begin
                            // Op 0 goes out now; lfsr keeps the state for the next op.
                            state      <= ISSUE;
                            pass       <= 1'b0;
                            alu_a      <= SEED_EFF[W-1:0];
                            alu_b      <= SEED_EFF[W+:W];
                            alu_opcode <= op_mode[2] ? 2'd0 : op_mode[1:0];
                            lfsr       <= lfsr_step(SEED_EFF);
                        end
                    end
                end
                ISSUE: begin
                    if (op_idx == num_q - 1'b1) begin
                        state      <= DRAIN;
                        drain_cnt  <= '0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        alu_opcode <= '0;
                    end else begin
                        op_idx     <= idx_inc;
                        alu_a      <= lfsr[W-1:0];
                        alu_b      <= lfsr[W+:W];
                        alu_opcode <= mode_q[2] ? idx_inc[1:0] : mode_q[1:0];
                        lfsr       <= lfsr_step(lfsr);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(LATENCY - 1)) begin
                        state <= DONE;
                        pass  <= (err_nxt == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver with a registered golden ALU model that can
// corrupt one chosen operation.
module tb_alu_seq_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_ops;
    logic [2:0] op_mode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_opcode;
    logic [7:0] alu_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_err;

    int errors = 0;
    int checks = 0;
    int inject_k = -1;
    int mcnt = 0;

    logic [3:0] lit_a [4] = '{4'h5, 4'hA, 4'h5, 4'h2};
    logic [3:0] lit_b [4] = '{4'hA, 4'hE, 4'h7, 4'h8};

    alu_seq_driver dut (
        .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .op_mode(op_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err(first_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        logic [7:0] ax;
        logic [7:0] bx;
        ax = {4'h0, a};
        bx = {4'h0, b};
        case (op)
            2'd0:    return ax + bx;
            2'd1:    return ax | bx;
            2'd2:    return ax - bx;
            default: return ax ^ bx;
        endcase
    endfunction

    function automatic logic [7:0] ref_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] model_out(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op, input logic flip);
        logic [7:0] v;
        v = golden(a, b, op);
        if (flip) v[0] = ~v[0];
        return v;
    endfunction

    // Registered ALU, one cycle latency; op k is on the port during the k-th busy cycle.
    always @(posedge clk) begin
        alu_out <= model_out(alu_a, alu_b, alu_opcode, busy && (mcnt == inject_k));
        mcnt    <= busy ? mcnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_ops(input int n, input logic [2:0] mode, input int restart_at,
                           input int exp_err, input int exp_first);
        logic [7:0] r;
        logic [1:0] exp_op;
        r = 8'hA5;
        @(negedge clk);
        start = 1'b1; num_ops = 8'(n); op_mode = mode;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_op = mode[2] ? 2'(k) : mode[1:0];
            check("issue_busy", busy, 1);
            check("issue_done", done, 0);
            check("issue_a", alu_a, r[3:0]);
            check("issue_b", alu_b, r[7:4]);
            check("issue_opcode", alu_opcode, exp_op);
            if (k < 4) begin
                check("lit_a", alu_a, lit_a[k]);
                check("lit_b", alu_b, lit_b[k]);
            end
            r = ref_step(r);
            if (k == restart_at) begin
                start = 1'b1; num_ops = 8'd3; op_mode = 3'b000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
        check("drain_a", alu_a, 0);
        check("drain_b", alu_b, 0);
        check("drain_opcode", alu_opcode, 0);
        @(negedge clk);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_err_count", err_count, exp_err);
        check("end_first_err", first_err, exp_first);
        check("end_pass", pass, (exp_err == 0) ? 1 : 0);
        @(negedge clk);
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("pass_held", pass, (exp_err == 0) ? 1 : 0);
        check("err_held", err_count, exp_err);
    endtask

    initial begin
        // T1: reset with start held high
        rst = 1'b1; start = 1'b1; num_ops = 8'd5; op_mode = 3'b100;
        repeat (2) @(negedge clk);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_err", first_err, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        // T2: zero-length run
        start = 1'b1; num_ops = 8'd0; op_mode = 3'b100;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_pass", pass, 1);
        check("zero_err", err_count, 0);
        @(negedge clk);
        check("zero_done_low", done, 0);
        check("zero_busy_low", busy, 0);
        check("zero_pass_held", pass, 1);

        // T3: long cycling-opcode run against the golden ALU
        run_ops(100, 3'b100, -1, 0, 0);

        // T4: single corrupted result at op 3
        inject_k = 3;
        run_ops(8, 3'b100, -1, 1, 3);
        inject_k = -1;

        // T5: fixed subtract (op 2 is 5-7 = 8'hFE), restart attempt mid-run ignored
        run_ops(6, 3'b010, 2, 0, 0);

        // T6: reset in the middle of a run, then a clean short run
        @(negedge clk);
        start = 1'b1; num_ops = 8'd20; op_mode = 3'b100;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t6_busy", busy, 1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_a", alu_a, 0);
        check("t6_abort_b", alu_b, 0);
        check("t6_abort_opcode", alu_opcode, 0);
        check("t6_abort_done", done, 0);
        check("t6_abort_err", err_count, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_no_done", done, 0);
            check("t6_idle_busy", busy, 0);
        end
        run_ops(4, 3'b100, -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
